// File: rtl/alu_arb_ctrl.sv
// Round-robin arbiter and sequencer for the shared sign-magnitude ALU.
// Grants one of two requesters, drives registered ALU operands, waits the settle time, returns the result.
module alu_arb_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 32'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [8:0] alu_c,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [8:0] rsp_data,
    output logic       rsp_id,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 32'd1);

    // Divide by a zero magnitude, or an op code the ALU does not implement.
    function automatic logic op_error(input logic [2:0] sel, input logic [7:0] b);
        return ((sel == 3'd3) && (b[6:0] == 7'd0)) || (sel >= 3'd6);
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic       last_grant_r;
    logic [3:0] cnt_r;
    logic       err_pend_r;
    logic       grant0_s;
    logic       grant1_s;
    logic       accept_s;
    logic [7:0] pick_a_s;
    logic [7:0] pick_b_s;
    logic [2:0] pick_sel_s;

    assign accept_s   = grant0_s | grant1_s;
    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Grant and busy outputs; reset suppresses readiness so a same-cycle request is never taken.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        busy     = (state_r != ST_IDLE);
        if (rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0_s = last_grant_r;
                grant1_s = ~last_grant_r;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Payload of the granted requester.
    always_comb begin
        pick_a_s   = req0_a;
        pick_b_s   = req0_b;
        pick_sel_s = req0_sel;
        if (grant1_s) begin
            pick_a_s   = req1_a;
            pick_b_s   = req1_b;
            pick_sel_s = req1_sel;
        end else begin
            pick_a_s   = req0_a;
            pick_b_s   = req0_b;
            pick_sel_s = req0_sel;
        end
    end

    // Operand latch, settle counter and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a        <= 8'd0;
            alu_b        <= 8'd0;
            alu_sel      <= 3'd0;
            rsp_valid    <= 1'b0;
            rsp_data     <= 9'd0;
            rsp_id       <= 1'b0;
            rsp_err      <= 1'b0;
            last_grant_r <= 1'b1;
            cnt_r        <= 4'd0;
            err_pend_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        alu_a        <= pick_a_s;
                        alu_b        <= pick_b_s;
                        alu_sel      <= pick_sel_s;
                        rsp_id       <= grant1_s;
                        last_grant_r <= grant1_s;
                        cnt_r        <= SETTLE_LOAD;
                        err_pend_r   <= op_error(pick_sel_s, pick_b_s);
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == 4'd0) begin
                        rsp_data  <= err_pend_r ? 9'd0 : alu_c;
                        rsp_err   <= err_pend_r;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: rsp_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Bench for alu_arb_ctrl: two instances (settle 1 and settle 4), a transaction-level reference
// checked on every negedge, plus directed scenarios with literal expectations.
module tb_alu_arb_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       r0v, r1v, rr;
    logic [7:0]       r0a, r0b, r1a, r1b;
    logic [2:0]       r0s, r1s;
    logic [8:0]       alu_c;
    logic [1:0]       rdy0, rdy1, rv, rid, rerr, bsy;
    logic [1:0][7:0]  oa, ob;
    logic [1:0][2:0]  osel;
    logic [1:0][8:0]  rdata;

    alu_arb_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v[0]), .req0_ready(rdy0[0]), .req0_a(r0a), .req0_b(r0b), .req0_sel(r0s),
        .req1_valid(r1v[0]), .req1_ready(rdy1[0]), .req1_a(r1a), .req1_b(r1b), .req1_sel(r1s),
        .alu_a(oa[0]), .alu_b(ob[0]), .alu_sel(osel[0]), .alu_c(alu_c),
        .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_data(rdata[0]), .rsp_id(rid[0]),
        .rsp_err(rerr[0]), .busy(bsy[0])
    );

    alu_arb_ctrl #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v[1]), .req0_ready(rdy0[1]), .req0_a(r0a), .req0_b(r0b), .req0_sel(r0s),
        .req1_valid(r1v[1]), .req1_ready(rdy1[1]), .req1_a(r1a), .req1_b(r1b), .req1_sel(r1s),
        .alu_a(oa[1]), .alu_b(ob[1]), .alu_sel(osel[1]), .alu_c(alu_c),
        .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_data(rdata[1]), .rsp_id(rid[1]),
        .rsp_err(rerr[1]), .busy(bsy[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int inst, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d actual=0x%h expected=0x%h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Reference: one outstanding transaction per instance, timed by edges since acceptance.
    logic            started = 1'b0;
    logic [1:0]      m_busy, m_rv, m_last, m_id, m_err, m_errp;
    logic [1:0][7:0] m_a, m_b;
    logic [1:0][2:0] m_sel;
    logic [1:0][8:0] m_data;
    int              m_age [2];

    function automatic logic bad_op(input logic [2:0] s, input logic [7:0] b);
        return (s == 3'd3 && (b & 8'h7F) == 8'h00) || (s > 3'd5);
    endfunction

    function automatic logic exp_ready(input int i, input int who);
        logic mine, other;
        mine  = (who == 0) ? r0v[i] : r1v[i];
        other = (who == 0) ? r1v[i] : r0v[i];
        if (rst || m_busy[i] || !mine) return 1'b0;
        if (!other) return 1'b1;
        return int'(m_last[i]) != who;
    endfunction

    always @(posedge clk) begin
        if (rst) started <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] <= 1'b0; m_rv[i] <= 1'b0; m_last[i] <= 1'b1; m_id[i] <= 1'b0;
                m_err[i] <= 1'b0; m_errp[i] <= 1'b0; m_a[i] <= 8'd0; m_b[i] <= 8'd0;
                m_sel[i] <= 3'd0; m_data[i] <= 9'd0; m_age[i] <= 0;
            end else if (!m_busy[i]) begin
                if (exp_ready(i, 0) || exp_ready(i, 1)) begin
                    m_busy[i] <= 1'b1;
                    m_age[i]  <= 0;
                    m_id[i]   <= exp_ready(i, 1);
                    m_last[i] <= exp_ready(i, 1);
                    m_a[i]    <= exp_ready(i, 1) ? r1a : r0a;
                    m_b[i]    <= exp_ready(i, 1) ? r1b : r0b;
                    m_sel[i]  <= exp_ready(i, 1) ? r1s : r0s;
                    m_errp[i] <= exp_ready(i, 1) ? bad_op(r1s, r1b) : bad_op(r0s, r0b);
                end
            end else if (!m_rv[i]) begin
                if (m_age[i] + 1 == ((i == 0) ? 1 : 4)) begin
                    m_rv[i]   <= 1'b1;
                    m_data[i] <= m_errp[i] ? 9'd0 : alu_c;
                    m_err[i]  <= m_errp[i];
                end
                m_age[i] <= m_age[i] + 1;
            end else if (rr[i]) begin
                m_rv[i]   <= 1'b0;
                m_busy[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                chk("req0_ready", i, rdy0[i], exp_ready(i, 0));
                chk("req1_ready", i, rdy1[i], exp_ready(i, 1));
                chk("busy", i, bsy[i], m_busy[i]);
                chk("alu_a", i, oa[i], m_a[i]);
                chk("alu_b", i, ob[i], m_b[i]);
                chk("alu_sel", i, osel[i], m_sel[i]);
                chk("rsp_valid", i, rv[i], m_rv[i]);
                chk("rsp_data", i, rdata[i], m_data[i]);
                chk("rsp_id", i, rid[i], m_id[i]);
                chk("rsp_err", i, rerr[i], m_err[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input int who, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        logic got;
        got = 1'b0;
        if (who == 0) begin r0a = a; r0b = b; r0s = s; r0v[i] = 1'b1; end
        else          begin r1a = a; r1b = b; r1s = s; r1v[i] = 1'b1; end
        #1;
        for (int k = 0; k < 40 && !got; k++) begin
            if ((who == 0) ? rdy0[i] : rdy1[i]) got = 1'b1;
            tick();
        end
        r0v[i] = 1'b0;
        r1v[i] = 1'b0;
        if (!got) chk("issue_handshake", i, (who == 0) ? rdy0[i] : rdy1[i], 9'd1);
    endtask

    task automatic wait_rsp(input int i, output int lat);
        lat = 0;
        while (!rv[i] && lat < 40) begin
            tick();
            lat++;
        end
        chk("rsp_arrives", i, rv[i], 9'd1);
    endtask

    int lat;
    int gl[$];
    int il[$];
    int exp_seq[4] = '{0, 1, 0, 1};

    initial begin
        rst = 1'b1; r0v = 2'b00; r1v = 2'b00; rr = 2'b00;
        r0a = 8'd0; r0b = 8'd0; r0s = 3'd0; r1a = 8'd0; r1b = 8'd0; r1s = 3'd0; alu_c = 9'd0;
        tick();
        r0v[0] = 1'b1; r1v[1] = 1'b1;
        #1;
        chk("ready_in_reset", 0, {rdy0[0], rdy1[0]}, 9'd0);
        chk("ready_in_reset", 1, {rdy0[1], rdy1[1]}, 9'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, bsy[i], 9'd0);
            chk("rst_rsp_valid", i, rv[i], 9'd0);
            chk("rst_alu_a", i, oa[i], 9'd0);
            chk("rst_rsp_data", i, rdata[i], 9'd0);
        end
        r0v = 2'b00; r1v = 2'b00;
        rst = 1'b0;
        tick();

        // Single add from req0, consumer always ready.
        alu_c = 9'h008; rr[0] = 1'b1;
        r0a = 8'h05; r0b = 8'h03; r0s = 3'd0; r0v[0] = 1'b1;
        #1;
        chk("t1_ready", 0, rdy0[0], 9'd1);
        tick();
        r0v[0] = 1'b0;
        wait_rsp(0, lat);
        chk("t1_latency", 0, 9'(lat), 9'd1);
        chk("t1_data", 0, rdata[0], 9'h008);
        chk("t1_id", 0, rid[0], 9'd0);
        chk("t1_err", 0, rerr[0], 9'd0);
        tick();
        chk("t1_idle", 0, bsy[0], 9'd0);

        // Continuous contention from reset: alternate grants.
        rst = 1'b1; tick(); rst = 1'b0;
        r0a = 8'h11; r0b = 8'h02; r0s = 3'd0; r1a = 8'h22; r1b = 8'h01; r1s = 3'd1;
        alu_c = 9'h033; rr[0] = 1'b1; r0v[0] = 1'b1; r1v[0] = 1'b1;
        #1;
        for (int c = 0; c < 60 && (gl.size() < 4 || il.size() < 4); c++) begin
            if (rdy0[0] && r0v[0]) gl.push_back(0);
            else if (rdy1[0] && r1v[0]) gl.push_back(1);
            if (rv[0] && rr[0]) il.push_back(int'(rid[0]));
            tick();
            if (gl.size() >= 4) begin r0v[0] = 1'b0; r1v[0] = 1'b0; end
        end
        for (int k = 0; k < 4; k++) begin
            chk("grant_order", 0, (k < gl.size()) ? 9'(gl[k]) : 9'h1FF, 9'(exp_seq[k]));
            chk("rsp_id_order", 0, (k < il.size()) ? 9'(il[k]) : 9'h1FF, 9'(exp_seq[k]));
        end

        // Error overrides: divide by zero, illegal op; a nonzero divisor passes through.
        alu_c = 9'h1FF;
        issue(0, 1, 8'h84, 8'h80, 3'd3);
        wait_rsp(0, lat);
        chk("div0_data", 0, rdata[0], 9'h000);
        chk("div0_err", 0, rerr[0], 9'd1);
        chk("div0_id", 0, rid[0], 9'd1);
        tick();
        issue(0, 1, 8'h05, 8'h03, 3'd7);
        wait_rsp(0, lat);
        chk("ill_data", 0, rdata[0], 9'h000);
        chk("ill_err", 0, rerr[0], 9'd1);
        tick();
        issue(0, 0, 8'h84, 8'h85, 3'd3);
        wait_rsp(0, lat);
        chk("div_ok_data", 0, rdata[0], 9'h1FF);
        chk("div_ok_err", 0, rerr[0], 9'd0);
        tick();

        // Backpressure with a waiting requester.
        rr[0] = 1'b0; alu_c = 9'h0AA;
        issue(0, 0, 8'h0A, 8'h01, 3'd4);
        wait_rsp(0, lat);
        r0a = 8'h33; r0v[0] = 1'b1;
        repeat (5) begin
            chk("bp_ready0", 0, rdy0[0], 9'd0);
            chk("bp_data", 0, rdata[0], 9'h0AA);
            chk("bp_valid", 0, rv[0], 9'd1);
            tick();
        end
        rr[0] = 1'b1;
        #1;
        chk("bp_no_accept_at_rsp_hs", 0, rdy0[0], 9'd0);
        tick();
        rr[0] = 1'b0;
        chk("bp_valid_clear", 0, rv[0], 9'd0);
        chk("bp_ready_next", 0, rdy0[0], 9'd1);
        tick();
        r0v[0] = 1'b0;
        chk("bp_reaccepted", 0, bsy[0], 9'd1);
        rr[0] = 1'b1;
        wait_rsp(0, lat);
        tick();

        // Settle of 4: the value present in the last EXEC cycle is captured.
        rr[1] = 1'b1;
        r0a = 8'h07; r0b = 8'h02; r0s = 3'd2; r0v[1] = 1'b1;
        #1;
        chk("s4_ready", 1, rdy0[1], 9'd1);
        tick();
        r0v[1] = 1'b0;
        lat = 0;
        alu_c = 9'h011;
        while (!rv[1] && lat < 20) begin
            tick();
            lat++;
            alu_c = 9'h011 + 9'(lat);
        end
        chk("s4_latency", 1, 9'(lat), 9'd4);
        chk("s4_data", 1, rdata[1], 9'h014);
        tick();
        rr[1] = 1'b0;

        // Reset while holding a response.
        rr[0] = 1'b0;
        issue(0, 0, 8'h01, 8'h01, 3'd0);
        wait_rsp(0, lat);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_resp_valid", 0, rv[0], 9'd0);
        chk("rst_resp_busy", 0, bsy[0], 9'd0);
        chk("rst_resp_data", 0, rdata[0], 9'd0);
        r0v[0] = 1'b1; r1v[0] = 1'b1;
        #1;
        chk("post_rst_grant0", 0, rdy0[0], 9'd1);
        chk("post_rst_grant1", 0, rdy1[0], 9'd0);
        tick();
        r0v[0] = 1'b0; r1v[0] = 1'b0; rr[0] = 1'b1;
        wait_rsp(0, lat);
        chk("post_rst_id", 0, rid[0], 9'd0);
        tick();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
